// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath.
// The master side (the controller) decodes opcode/ready and drives every datapath control line.
interface multicycle_main_ctrl_if;
  logic [5:0]  opcode_i;
  logic        mem_ready_i;
  logic        PCWrite_o;
  logic        PCWriteCond_o;
  logic        IorD_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        IRWrite_o;
  logic        RegDst_o;
  logic        MemtoReg_o;
  logic        RegWrite_o;
  logic        ALUSrcA_o;
  logic [1:0]  ALUSrcB_o;
  logic [2:0]  ALUOp_o;
  logic [1:0]  PCSource_o;
  logic [3:0]  state_o;
  logic        retire_o;
  logic        illegal_o;
  logic [15:0] instr_cnt_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o,
           MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, state_o,
           retire_o, illegal_o, instr_cnt_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o,
           MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, state_o,
           retire_o, illegal_o, instr_cnt_o
  );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing with
// ready-handshaked memory accesses and a retired-instruction counter.
module multicycle_main_ctrl (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_main_ctrl_if.master bus
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StMemAdr = 4'd3;
  localparam logic [3:0] StMemRd  = 4'd4;
  localparam logic [3:0] StMemWb  = 4'd5;
  localparam logic [3:0] StMemWr  = 4'd6;
  localparam logic [3:0] StRtExe  = 4'd7;
  localparam logic [3:0] StRtWb   = 4'd8;
  localparam logic [3:0] StIExe   = 4'd9;
  localparam logic [3:0] StIWb    = 4'd10;
  localparam logic [3:0] StBeq    = 4'd11;
  localparam logic [3:0] StJump   = 4'd12;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       retire, illegal;

  // Next-state and control decode; every line defaults to 0 for the current state.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b101;
        ir_write  = bus.mem_ready_i;
        pc_write  = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = 3'b101;
        case (bus.opcode_i)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRType:        state_d = StRtExe;
          OpAddi, OpSlti: state_d = StIExe;
          OpBeq:          state_d = StBeq;
          OpJ:            state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b101;
        state_d   = (bus.opcode_i == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = StFetch;
      end
      StRtExe: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = StRtWb;
      end
      StRtWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StIExe: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (bus.opcode_i == OpSlti) ? 3'b110 : 3'b101;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Retired-instruction count, wraps naturally at 16 bits.
  always_comb begin
    cnt_d = retire ? cnt_q + 16'd1 : cnt_q;
  end

  // State and counter registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite_o     = pc_write;
  assign bus.PCWriteCond_o = pc_write_cond;
  assign bus.IorD_o        = iord;
  assign bus.MemRead_o     = mem_read;
  assign bus.MemWrite_o    = mem_write;
  assign bus.IRWrite_o     = ir_write;
  assign bus.RegDst_o      = reg_dst;
  assign bus.MemtoReg_o    = mem_to_reg;
  assign bus.RegWrite_o    = reg_write;
  assign bus.ALUSrcA_o     = alu_src_a;
  assign bus.ALUSrcB_o     = alu_src_b;
  assign bus.ALUOp_o       = alu_op;
  assign bus.PCSource_o    = pc_source;
  assign bus.state_o       = state_q;
  assign bus.retire_o      = retire;
  assign bus.illegal_o     = illegal;
  assign bus.instr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl: hand-computed state walks and control values.
module tb_multicycle_main_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_main_ctrl_if bus ();

  multicycle_main_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of all single-bit/field controls for all-zero checks.
  function automatic logic [15:0] ctrl_or();
    ctrl_or = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o, bus.MemWrite_o,
               bus.IRWrite_o, bus.RegDst_o, bus.MemtoReg_o, bus.RegWrite_o, bus.ALUSrcA_o,
               bus.ALUSrcB_o, bus.ALUOp_o, bus.retire_o} |
              {15'd0, bus.illegal_o} | {14'd0, bus.PCSource_o};
  endfunction

  initial begin
    bus.opcode_i    = 6'h00;
    bus.mem_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_state", {12'd0, bus.state_o}, 16'd0);
    chk("rst_ctrl", ctrl_or(), 16'd0);
    chk("rst_aluop", {13'd0, bus.ALUOp_o}, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_state", {12'd0, bus.state_o}, 16'd0);
    chk("idle_cnt", bus.instr_cnt_o, 16'd0);

    // R-type: 0,1,2,7,8,1
    tick();
    chk("rt_fetch", {12'd0, bus.state_o}, 16'd1);
    chk("rt_fetch_irw", {15'd0, bus.IRWrite_o}, 16'd1);
    chk("rt_fetch_pcw", {15'd0, bus.PCWrite_o}, 16'd1);
    chk("rt_fetch_mr", {15'd0, bus.MemRead_o}, 16'd1);
    chk("rt_fetch_srcb", {14'd0, bus.ALUSrcB_o}, 16'd1);
    chk("rt_fetch_aluop", {13'd0, bus.ALUOp_o}, 16'd5);
    tick();
    chk("rt_decode", {12'd0, bus.state_o}, 16'd2);
    chk("rt_decode_srcb", {14'd0, bus.ALUSrcB_o}, 16'd3);
    tick();
    chk("rt_exe", {12'd0, bus.state_o}, 16'd7);
    chk("rt_exe_aluop", {13'd0, bus.ALUOp_o}, 16'd2);
    chk("rt_exe_srca", {15'd0, bus.ALUSrcA_o}, 16'd1);
    tick();
    chk("rt_wb", {12'd0, bus.state_o}, 16'd8);
    chk("rt_wb_rw", {15'd0, bus.RegWrite_o}, 16'd1);
    chk("rt_wb_rd", {15'd0, bus.RegDst_o}, 16'd1);
    chk("rt_wb_ret", {15'd0, bus.retire_o}, 16'd1);
    tick();
    chk("rt_back_fetch", {12'd0, bus.state_o}, 16'd1);
    chk("rt_cnt", bus.instr_cnt_o, 16'd1);

    // lw with two MEMRD wait cycles: 1,2,3,4,4,4,5,1
    bus.opcode_i = 6'h23;
    tick();
    chk("lw_decode", {12'd0, bus.state_o}, 16'd2);
    tick();
    chk("lw_memadr", {12'd0, bus.state_o}, 16'd3);
    chk("lw_memadr_srcb", {14'd0, bus.ALUSrcB_o}, 16'd2);
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lw_memrd_wait", {12'd0, bus.state_o}, 16'd4);
      chk("lw_memrd_iord", {15'd0, bus.IorD_o}, 16'd1);
      chk("lw_memrd_mr", {15'd0, bus.MemRead_o}, 16'd1);
    end
    tick();
    bus.mem_ready_i = 1'b1;
    #1;
    chk("lw_memrd_rdy", {12'd0, bus.state_o}, 16'd4);
    chk("lw_memrd_iord3", {15'd0, bus.IorD_o}, 16'd1);
    tick();
    chk("lw_memwb", {12'd0, bus.state_o}, 16'd5);
    chk("lw_memwb_m2r", {15'd0, bus.MemtoReg_o}, 16'd1);
    chk("lw_memwb_ret", {15'd0, bus.retire_o}, 16'd1);
    tick();
    chk("lw_fetch", {12'd0, bus.state_o}, 16'd1);
    chk("lw_cnt", bus.instr_cnt_o, 16'd2);

    // FETCH stalled for 3 cycles, then slti
    bus.mem_ready_i = 1'b0;
    bus.opcode_i    = 6'h0A;
    #1;
    chk("fw_irw0", {15'd0, bus.IRWrite_o}, 16'd0);
    chk("fw_pcw0", {15'd0, bus.PCWrite_o}, 16'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fw_state", {12'd0, bus.state_o}, 16'd1);
      chk("fw_irw", {15'd0, bus.IRWrite_o}, 16'd0);
    end
    tick();
    bus.mem_ready_i = 1'b1;
    #1;
    chk("fw_state_rdy", {12'd0, bus.state_o}, 16'd1);
    chk("fw_irw_rdy", {15'd0, bus.IRWrite_o}, 16'd1);
    chk("fw_pcw_rdy", {15'd0, bus.PCWrite_o}, 16'd1);
    tick();
    chk("slti_decode", {12'd0, bus.state_o}, 16'd2);
    chk("slti_decode_irw", {15'd0, bus.IRWrite_o}, 16'd0);
    tick();
    chk("slti_iexe", {12'd0, bus.state_o}, 16'd9);
    chk("slti_aluop", {13'd0, bus.ALUOp_o}, 16'd6);
    chk("slti_srcb", {14'd0, bus.ALUSrcB_o}, 16'd2);
    tick();
    chk("slti_iwb", {12'd0, bus.state_o}, 16'd10);
    chk("slti_iwb_rw", {15'd0, bus.RegWrite_o}, 16'd1);
    chk("slti_iwb_rd", {15'd0, bus.RegDst_o}, 16'd0);
    tick();
    chk("slti_cnt", bus.instr_cnt_o, 16'd3);

    // beq
    bus.opcode_i = 6'h04;
    tick();
    tick();
    chk("beq_state", {12'd0, bus.state_o}, 16'd11);
    chk("beq_aluop", {13'd0, bus.ALUOp_o}, 16'd1);
    chk("beq_pcwc", {15'd0, bus.PCWriteCond_o}, 16'd1);
    chk("beq_pcsrc", {14'd0, bus.PCSource_o}, 16'd1);
    chk("beq_ret", {15'd0, bus.retire_o}, 16'd1);
    tick();
    chk("beq_fetch", {12'd0, bus.state_o}, 16'd1);
    chk("beq_cnt", bus.instr_cnt_o, 16'd4);

    // Illegal opcode: DECODE -> FETCH, single illegal pulse, no count
    bus.opcode_i = 6'h3F;
    tick();
    chk("ill_decode", {12'd0, bus.state_o}, 16'd2);
    chk("ill_pulse", {15'd0, bus.illegal_o}, 16'd1);
    chk("ill_noret", {15'd0, bus.retire_o}, 16'd0);
    tick();
    chk("ill_fetch", {12'd0, bus.state_o}, 16'd1);
    chk("ill_pulse_off", {15'd0, bus.illegal_o}, 16'd0);
    chk("ill_cnt", bus.instr_cnt_o, 16'd4);

    // j
    bus.opcode_i = 6'h02;
    tick();
    tick();
    chk("j_state", {12'd0, bus.state_o}, 16'd12);
    chk("j_pcw", {15'd0, bus.PCWrite_o}, 16'd1);
    chk("j_pcsrc", {14'd0, bus.PCSource_o}, 16'd2);
    tick();
    chk("j_cnt", bus.instr_cnt_o, 16'd5);

    // Counter wrap: force to 0xFFFF mid-cycle in FETCH, then retire one j
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", bus.instr_cnt_o, 16'hFFFF);
    tick();
    tick();
    chk("wrap_j", {12'd0, bus.state_o}, 16'd12);
    tick();
    chk("wrap_cnt", bus.instr_cnt_o, 16'h0000);

    // beq to make the count nonzero, then sw with reset during the retiring MEMWR cycle
    bus.opcode_i = 6'h04;
    tick();
    tick();
    tick();
    chk("post_wrap_cnt", bus.instr_cnt_o, 16'd1);
    bus.opcode_i = 6'h2B;
    tick();
    tick();
    chk("sw_memadr", {12'd0, bus.state_o}, 16'd3);
    bus.mem_ready_i = 1'b0;
    tick();
    chk("sw_memwr", {12'd0, bus.state_o}, 16'd6);
    chk("sw_memwr_mw", {15'd0, bus.MemWrite_o}, 16'd1);
    chk("sw_memwr_noret", {15'd0, bus.retire_o}, 16'd0);
    tick();
    chk("sw_memwr_hold", {12'd0, bus.state_o}, 16'd6);
    bus.mem_ready_i = 1'b1;
    #1;
    chk("sw_memwr_ret", {15'd0, bus.retire_o}, 16'd1);
    rst = 1'b1;
    #1;
    chk("abort_state", {12'd0, bus.state_o}, 16'd0);
    chk("abort_cnt", bus.instr_cnt_o, 16'd0);
    chk("abort_ctrl", ctrl_or(), 16'd0);
    tick();
    chk("abort_hold_cnt", bus.instr_cnt_o, 16'd0);
    rst = 1'b0;
    tick();
    chk("restart_fetch", {12'd0, bus.state_o}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
